mem_port_arbiter: RTL and testbench

//   Shares one memory port (read/write/resp handshake) between two requesters: port 0 (instruction fetch)
//   and port 1 (data). Round-robin arbitration, one outstanding transaction, registered outputs.

---
 rtl/mem_port_arbiter_if.sv | 25 ++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: read/write/resp memory handshake bundle.
// master drives the command; slave returns rdata/resp/error.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  read;
  logic                  write;
  logic [ADDR_W-1:0]     address;
  logic [DATA_W-1:0]     wdata;
  logic [DATA_W/8-1:0]   byte_enable;
  logic [DATA_W-1:0]     rdata;
  logic                  resp;
  logic                  error;

  modport master (
    output read, write, address, wdata, byte_enable,
    input  rdata, resp, error
  );

  modport slave (
    input  read, write, address, wdata, byte_enable,
    output rdata, resp, error
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin share of one memory port between
// fetch (p0) and data (p1); one outstanding txn, response timeout.
// Ports: clk; rst (async, active-high); p0/p1 requester slave
// ports; mem master port toward the memory.
module mem_port_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic rst,
  mem_port_arbiter_if.slave  p0,
  mem_port_arbiter_if.slave  p1,
  mem_port_arbiter_if.master mem
);
  localparam int BE_W = DATA_W / 8;
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic              last_grant_q, last_grant_d;
  logic              grant_q, grant_d;
  logic [31:0]       timer_q, timer_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              p0_resp_q, p0_resp_d;
  logic              p1_resp_q, p1_resp_d;
  logic              p0_error_q, p0_error_d;
  logic              p1_error_q, p1_error_d;

  logic              req0, req1, sel, sel_wr, timed_out;
  logic              r_err, r_upd;
  logic [DATA_W-1:0] r_data;

  assign req0 = p0.read | p0.write;
  assign req1 = p1.read | p1.write;

  // TIMEOUT==0 disables the watchdog entirely
  assign timed_out = (TIMEOUT != 0) && (timer_q == TMO_LAST);

  always_comb begin
    sel = 1'b0;
    unique case (1'b1)
      (req0 && req1):  sel = ~last_grant_q;
      (req1 && !req0): sel = 1'b1;
      default:         sel = 1'b0;
    endcase
  end

  // write wins when a requester raises both read and write
  assign sel_wr = sel ? p1.write : p0.write;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    timer_d      = timer_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    p0_resp_d    = 1'b0;
    p1_resp_d    = 1'b0;
    p0_error_d   = 1'b0;
    p1_error_d   = 1'b0;
    r_err        = 1'b0;
    r_upd        = 1'b0;
    r_data       = '0;

    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          grant_d      = sel;
          last_grant_d = sel;
          addr_d       = sel ? p1.address : p0.address;
          wdata_d      = sel ? p1.wdata : p0.wdata;
          be_d         = sel ? p1.byte_enable : p0.byte_enable;
          mem_write_d  = sel_wr;
          mem_read_d   = ~sel_wr;
          timer_d      = '0;
          state_d      = BUSY;
        end
      end
      BUSY: begin
        timer_d = timer_q + 32'd1;
        if (mem.resp || timed_out) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          state_d     = RESP;
          // a real response beats a same-cycle timeout
          if (mem.resp) begin
            r_err  = mem.error;
            r_upd  = mem_read_q;
            r_data = mem.rdata;
          end else begin
            r_err  = 1'b1;
            r_upd  = 1'b1;
            r_data = '0;
          end
          if (grant_q) begin
            p1_resp_d  = 1'b1;
            p1_error_d = r_err;
            if (r_upd) p1_rdata_d = r_data;
          end else begin
            p0_resp_d  = 1'b1;
            p0_error_d = r_err;
            if (r_upd) p0_rdata_d = r_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      timer_q      <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      p0_resp_q    <= 1'b0;
      p1_resp_q    <= 1'b0;
      p0_error_q   <= 1'b0;
      p1_error_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      timer_q      <= timer_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      p0_resp_q    <= p0_resp_d;
      p1_resp_q    <= p1_resp_d;
      p0_error_q   <= p0_error_d;
      p1_error_q   <= p1_error_d;
    end
  end

  assign mem.read        = mem_read_q;
  assign mem.write       = mem_write_q;
  assign mem.address     = addr_q;
  assign mem.wdata       = wdata_q;
  assign mem.byte_enable = be_q;

  assign p0.rdata = p0_rdata_q;
  assign p0.resp  = p0_resp_q;
  assign p0.error = p0_error_q;
  assign p1.rdata = p1_rdata_q;
  assign p1.resp  = p1_resp_q;
  assign p1.error = p1_error_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner sequences and
// random transactions against a transaction-level model.
module tb_mem_port_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p0_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) p1_if ();
  mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .p0(p0_if),
    .p1(p1_if),
    .mem(mem_if)
  );

  int total = 0;
  int bad = 0;

  // model state: last granted port, last rdata seen per port
  int          last_g;
  logic [31:0] prev_rd [2];

  // random-phase pending requests
  bit          pend [2];
  bit          pwr [2];
  logic [31:0] pad [2];
  logic [31:0] pwd [2];
  logic [3:0]  pbe [2];

  typedef struct {
    bit r0;
    bit w0;
    bit r1;
    bit w1;
    int exp_g;
    bit exp_wr;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    last_g = 1;
    prev_rd[0] = '0;
    prev_rd[1] = '0;
  endtask

  task automatic set_port(input int g, input logic rd, input logic wr,
                          input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
    if (g == 0) begin
      p0_if.read = rd; p0_if.write = wr; p0_if.address = a;
      p0_if.wdata = d; p0_if.byte_enable = be;
    end else begin
      p1_if.read = rd; p1_if.write = wr; p1_if.address = a;
      p1_if.wdata = d; p1_if.byte_enable = be;
    end
  endtask

  function automatic logic get_resp(input int g);
    return (g == 0) ? p0_if.resp : p1_if.resp;
  endfunction

  function automatic logic get_err(input int g);
    return (g == 0) ? p0_if.error : p1_if.error;
  endfunction

  function automatic logic [31:0] get_rd(input int g);
    return (g == 0) ? p0_if.rdata : p1_if.rdata;
  endfunction

  task automatic apply_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_reset();
  endtask

  // One full transaction from IDLE with port g's request already driven.
  // lat = BUSY cycles until the memory answers; beyond TMO it times out.
  task automatic do_txn(input int g, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        input int lat, input logic [31:0] mrd,
                        input bit merr, input bit stray, input bit wiggle);
    int o;
    int n;
    bit to;
    logic [31:0] exp_rd;
    logic exp_err;
    o  = 1 - g;
    to = (lat > TMO);
    n  = to ? TMO : lat;
    step();
    chk("grant_read", mem_if.read, !wr);
    chk("grant_write", mem_if.write, wr);
    chk("grant_addr", mem_if.address, addr);
    if (wr) begin
      chk("grant_wdata", mem_if.wdata, wd);
      chk("grant_be", mem_if.byte_enable, be);
    end
    chk("grant_noresp", {p0_if.resp, p1_if.resp}, 0);
    for (int i = 1; i <= n; i++) begin
      mem_if.resp  = (i == lat);
      mem_if.rdata = (i == lat) ? mrd : $urandom;
      mem_if.error = (i == lat) ? merr : 1'($urandom);
      if (wiggle)
        set_port(g, 1'($urandom), 1'($urandom), $urandom, $urandom,
                 4'($urandom));
      step();
      mem_if.resp = 1'b0;
      if (i < n) begin
        chk("busy_cmd", {mem_if.read, mem_if.write}, {!wr, wr});
        chk("busy_addr", mem_if.address, addr);
        chk("busy_noresp", {p0_if.resp, p1_if.resp}, 0);
      end
    end
    if (to) begin
      exp_rd  = '0;
      exp_err = 1'b1;
    end else begin
      exp_rd  = wr ? prev_rd[g] : mrd;
      exp_err = merr;
    end
    chk("done_cmd", {mem_if.read, mem_if.write}, 0);
    chk("done_resp", get_resp(g), 1);
    chk("done_rdata", get_rd(g), exp_rd);
    chk("done_error", get_err(g), exp_err);
    chk("other_resp", get_resp(o), 0);
    chk("other_rdata", get_rd(o), prev_rd[o]);
    prev_rd[g] = exp_rd;
    last_g = g;
    set_port(g, 1'b0, 1'b0, '0, '0, '0);
    if (stray) begin
      mem_if.resp  = 1'b1;
      mem_if.error = 1'b1;
      mem_if.rdata = 32'hFFFF_0000;
    end
    step();
    mem_if.resp = 1'b0;
    chk("after_resp", {p0_if.resp, p1_if.resp}, 0);
    chk("after_err", {p0_if.error, p1_if.error}, 0);
    chk("after_cmd", {mem_if.read, mem_if.write}, 0);
    chk("after_rdata", {get_rd(0), get_rd(1)}, {prev_rd[0], prev_rd[1]});
  endtask

  task automatic new_req(input int p);
    pend[p] = 1'b1;
    pwr[p]  = 1'($urandom);
    pad[p]  = $urandom;
    pwd[p]  = $urandom;
    pbe[p]  = 4'($urandom);
    set_port(p, !pwr[p], pwr[p], pad[p], pwd[p], pbe[p]);
  endtask

  initial begin
    int g;
    int ng;
    int nr;
    int n0;
    int gc;
    logic prev_cmd;

    tbl[0] = '{1, 0, 0, 0, 0, 0};
    tbl[1] = '{1, 0, 1, 0, 1, 0};
    tbl[2] = '{0, 1, 1, 0, 0, 1};
    tbl[3] = '{0, 0, 0, 1, 1, 1};
    tbl[4] = '{0, 0, 1, 0, 1, 0};
    tbl[5] = '{1, 0, 0, 1, 0, 0};
    tbl[6] = '{1, 1, 0, 0, 0, 1};
    tbl[7] = '{1, 0, 1, 1, 1, 1};

    rst = 1'b1;
    set_port(0, 1'b0, 1'b0, '0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0, '0);
    mem_if.resp = 1'b0;
    mem_if.error = 1'b0;
    mem_if.rdata = '0;
    model_reset();
    #12;
    chk("rst_cmd", {mem_if.read, mem_if.write}, 0);
    chk("rst_resp", {p0_if.resp, p1_if.resp}, 0);
    chk("rst_err", {p0_if.error, p1_if.error}, 0);
    chk("rst_rdata", {p0_if.rdata, p1_if.rdata}, 0);
    chk("rst_addr", mem_if.address, 0);
    step();
    rst = 1'b0;

    // single fetch read
    set_port(0, 1'b1, 1'b0, 32'h100, '0, '0);
    do_txn(0, 0, 32'h100, '0, '0, 2, 32'hDEAD_BEEF, 0, 0, 0);

    // tie after reset, then alternation
    apply_reset();
    set_port(0, 1'b1, 1'b0, 32'h40, '0, '0);
    set_port(1, 1'b0, 1'b1, 32'h80, 32'h1234_5678, 4'b0011);
    do_txn(0, 0, 32'h40, '0, '0, 1, 32'hA5A5_0001, 0, 0, 0);
    do_txn(1, 1, 32'h80, 32'h1234_5678, 4'b0011, 1, 32'h0, 0, 0, 0);
    set_port(0, 1'b1, 1'b0, 32'h44, '0, '0);
    set_port(1, 1'b1, 1'b0, 32'h84, '0, '0);
    do_txn(0, 0, 32'h44, '0, '0, 1, 32'h0000_0044, 0, 0, 0);
    do_txn(1, 0, 32'h84, '0, '0, 2, 32'h0000_0084, 0, 0, 0);

    // hung memory, then a stray late response in IDLE
    set_port(0, 1'b1, 1'b0, 32'h300, '0, '0);
    do_txn(0, 0, 32'h300, '0, '0, 20, '0, 0, 0, 0);
    mem_if.resp = 1'b1;
    mem_if.rdata = 32'hBAD0_BAD0;
    step();
    mem_if.resp = 1'b0;
    chk("stray_resp", {p0_if.resp, p1_if.resp}, 0);
    chk("stray_cmd", {mem_if.read, mem_if.write}, 0);
    chk("stray_rdata", p0_if.rdata, prev_rd[0]);

    // memory error on p1; resp and timeout on the same edge
    set_port(1, 1'b1, 1'b0, 32'h400, '0, '0);
    do_txn(1, 0, 32'h400, '0, '0, 1, 32'h1111_1111, 1, 0, 0);
    set_port(1, 1'b1, 1'b0, 32'h404, '0, '0);
    do_txn(1, 0, 32'h404, '0, '0, TMO, 32'h2222_2222, 0, 0, 0);

    // arbitration/op vector table from reset
    apply_reset();
    for (int i = 0; i < 8; i++) begin
      logic [31:0] a0, a1, wd;
      a0 = 32'h1000 + 32'(i * 16);
      a1 = 32'h2000 + 32'(i * 16);
      wd = 32'hA000_0000 + 32'(i);
      set_port(0, tbl[i].r0, tbl[i].w0, a0, wd, 4'hF);
      set_port(1, tbl[i].r1, tbl[i].w1, a1, wd, 4'hF);
      do_txn(tbl[i].exp_g, tbl[i].exp_wr, tbl[i].exp_g ? a1 : a0, wd,
             4'hF, 1 + (i % 3), 32'h5000 + 32'(i), 0, 0, 0);
      set_port(0, 1'b0, 1'b0, '0, '0, '0);
      set_port(1, 1'b0, 1'b0, '0, '0, '0);
    end

    // reset in the middle of BUSY, away from any clock edge
    set_port(0, 1'b1, 1'b0, 32'h500, '0, '0);
    step();
    chk("r5_grant", mem_if.read, 1);
    step();
    #3;
    rst = 1'b1;
    #1;
    chk("r5_cmd_drop", {mem_if.read, mem_if.write}, 0);
    chk("r5_noresp", {p0_if.resp, p1_if.resp}, 0);
    step();
    chk("r5_held", {mem_if.read, p0_if.resp}, 0);
    rst = 1'b0;
    model_reset();
    set_port(1, 1'b1, 1'b0, 32'h600, '0, '0);
    do_txn(0, 0, 32'h500, '0, '0, 1, 32'h0000_0500, 0, 0, 0);
    do_txn(1, 0, 32'h600, '0, '0, 1, 32'h0000_0600, 0, 0, 0);

    // back-to-back grants on a continuously held p1 read
    apply_reset();
    mem_if.rdata = 32'hC0DE_0000;
    mem_if.error = 1'b0;
    set_port(1, 1'b1, 1'b0, 32'h700, '0, '0);
    ng = 0; nr = 0; n0 = 0; gc = 0; prev_cmd = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      mem_if.resp = mem_if.read | mem_if.write;
      step();
      if (mem_if.read && !prev_cmd) begin
        if (ng > 0) chk("t6_spacing", 64'(c - gc), 3);
        else chk("t6_first", 64'(c), 1);
        gc = c;
        ng++;
      end
      prev_cmd = mem_if.read;
      if (p1_if.resp) begin
        nr++;
        if (nr == 4) set_port(1, 1'b0, 1'b0, '0, '0, '0);
      end
      if (p0_if.resp) n0++;
    end
    mem_if.resp = 1'b0;
    chk("t6_grants", 64'(ng), 4);
    chk("t6_resps", 64'(nr), 4);
    chk("t6_p0_idle", 64'(n0), 0);
    chk("t6_rdata", p1_if.rdata, 32'hC0DE_0000);
    last_g = 1;
    prev_rd[1] = 32'hC0DE_0000;

    // random traffic
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int t = 0; t < 150; t++) begin
      for (int p = 0; p < 2; p++)
        if (!pend[p] && $urandom_range(0, 2) != 0) new_req(p);
      if (!pend[0] && !pend[1]) new_req(t % 2);
      if (pend[0] && pend[1]) g = 1 - last_g;
      else g = pend[1] ? 1 : 0;
      do_txn(g, pwr[g], pad[g], pwd[g], pbe[g],
             int'($urandom_range(1, 11)), $urandom,
             ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
      pend[g] = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
